// File: rtl/vt_attack_control_pkg.sv
// vt_attack_control_pkg
// Shared definitions for the attack sequencing controllers: HP width,
// starting HP, per-move damage constants, the Volt Tackle state enum and
// a saturating-subtract helper used by the HP registers.
// No ports (package).
package vt_attack_control_pkg;

  localparam int              HP_W      = 8;
  localparam logic [HP_W-1:0] MAX_HP    = HP_W'(100);
  localparam logic [HP_W-1:0] VT_DAMAGE = HP_W'(40);
  // Recoil taken by Pikachu when the recoil build option is enabled.
  localparam logic [HP_W-1:0] VT_RECOIL = VT_DAMAGE >> 2;

  // VT_APPLY is the damage-application state; it cannot be named VT_DAMAGE
  // because that identifier is the damage constant above.
  typedef enum logic [2:0] {
    VT_IDLE       = 3'd0,
    VT_CLEAR      = 3'd1,
    VT_DRAW_PIKA  = 3'd2,
    VT_FRAME_WAIT = 3'd3,
    VT_DRAW_HURT  = 3'd4,
    VT_HOLD       = 3'd5,
    VT_APPLY      = 3'd6,
    VT_DONE       = 3'd7
  } vt_state_t;

  // Compare before subtracting so the result floors at zero instead of wrapping.
  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                               input logic [HP_W-1:0] b);
    return (a >= b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/vt_attack_control_if.sv
// vt_attack_control_if
// Connection between the controller and the volt_tackle drawing stage.
//   master (controller): drives stage_resetn, enables, choose, plot;
//                        receives the stage done flags.
//   slave  (stage):      the mirror image.
interface vt_attack_control_if;
  logic done_animate_vt;
  logic done_pikachu_vt;
  logic done_shift;
  logic done_vt;
  logic done_hurt_meowth;

  logic stage_resetn;
  logic enable_animate;
  logic enable_p_vt;
  logic enable_draw_pika_vt;
  logic enable_draw_hurt_meowth;
  logic choose;
  logic plot;

  modport master (
    input  done_animate_vt, done_pikachu_vt, done_shift, done_vt, done_hurt_meowth,
    output stage_resetn, enable_animate, enable_p_vt, enable_draw_pika_vt,
           enable_draw_hurt_meowth, choose, plot
  );

  modport slave (
    output done_animate_vt, done_pikachu_vt, done_shift, done_vt, done_hurt_meowth,
    input  stage_resetn, enable_animate, enable_p_vt, enable_draw_pika_vt,
           enable_draw_hurt_meowth, choose, plot
  );
endinterface

// File: rtl/vt_attack_control_hp_register.sv
// vt_attack_control_hp_register (the hp_register of one combatant)
// Holds one HP value: reload to MAX_HP on reset or load, saturating
// subtract of amount on sub_en, and a zero flag.
// Ports: clock, reset_all (sync, active-high), load, sub_en, amount,
//        hp (current value), zero (hp == 0).
module vt_attack_control_hp_register
  import vt_attack_control_pkg::*;
(
  input  logic            clock,
  input  logic            reset_all,
  input  logic            load,
  input  logic            sub_en,
  input  logic [HP_W-1:0] amount,
  output logic [HP_W-1:0] hp,
  output logic            zero
);

  // load has priority over sub_en, so a new battle beats a coincident hit.
  always_ff @(posedge clock) begin
    if (reset_all) begin
      hp <= MAX_HP;
    end else if (load) begin
      hp <= MAX_HP;
    end else if (sub_en) begin
      hp <= sat_sub(hp, amount);
    end
  end

  assign zero = (hp == '0);

endmodule

// File: rtl/vt_attack_control.sv
// vt_attack_control
// Sequencing controller for the Volt Tackle attack. Drives the volt_tackle
// stage enables/select/reset, gates the VGA plot strobe, applies damage at
// the end of the animation and pulses attack_done.
// Ports: clock, reset_all (sync, active-high), new_battle, start,
//        stage (vt_attack_control_if.master), busy, attack_done,
//        meowth_hp, pika_hp, meowth_fainted.
// Build option: VT_RECOIL_EN -- Pikachu takes VT_DAMAGE>>2 recoil on each
// hit and cannot start the attack at zero HP.
//
// state          | meaning
// VT_IDLE        | waiting for start
// VT_CLEAR       | one-cycle reset of the stage counters
// VT_DRAW_PIKA   | plotting the Pikachu sprite
// VT_FRAME_WAIT  | animating, waiting for a frame tick or end of shift
// VT_DRAW_HURT   | plotting the hurt Meowth sprite
// VT_HOLD        | waiting for the whole animation to finish
// VT_APPLY       | damage applied on the exit edge
// VT_DONE        | attack_done pulse
module vt_attack_control
  import vt_attack_control_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_all,
  input  logic                  new_battle,
  input  logic                  start,
  vt_attack_control_if.master   stage,
  output logic                  busy,
  output logic                  attack_done,
  output logic [HP_W-1:0]       meowth_hp,
  output logic [HP_W-1:0]       pika_hp,
  output logic                  meowth_fainted
);

  vt_state_t state_q, state_d;
  logic      pika_zero;
  logic      can_start;
  logic      pika_sub;

`ifdef VT_RECOIL_EN
  assign can_start = ~meowth_fainted & ~pika_zero;
  assign pika_sub  = (state_q == VT_APPLY);
`else
  logic unused_pika_zero;
  assign unused_pika_zero = pika_zero;
  assign can_start = ~meowth_fainted;
  assign pika_sub  = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset_all) begin
      state_q <= VT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      VT_IDLE:       if (start && can_start) state_d = VT_CLEAR;
      VT_CLEAR:      state_d = VT_DRAW_PIKA;
      VT_DRAW_PIKA:  if (stage.done_pikachu_vt) state_d = VT_FRAME_WAIT;
      // End of shift outranks a coincident frame tick.
      VT_FRAME_WAIT: begin
        if (stage.done_shift)           state_d = VT_DRAW_HURT;
        else if (stage.done_animate_vt) state_d = VT_DRAW_PIKA;
      end
      VT_DRAW_HURT:  if (stage.done_hurt_meowth) state_d = VT_HOLD;
      VT_HOLD:       if (stage.done_vt) state_d = VT_APPLY;
      VT_APPLY:      state_d = VT_DONE;
      VT_DONE:       state_d = VT_IDLE;
      default:       state_d = VT_IDLE;
    endcase
  end

  always_comb begin
    stage.stage_resetn            = 1'b1;
    stage.enable_animate          = 1'b0;
    stage.enable_draw_pika_vt     = 1'b0;
    stage.enable_draw_hurt_meowth = 1'b0;
    stage.choose                  = 1'b0;
    stage.plot                    = 1'b0;
    attack_done                   = 1'b0;
    busy                          = (state_q != VT_IDLE);
    case (state_q)
      VT_CLEAR:      stage.stage_resetn = 1'b0;
      VT_DRAW_PIKA: begin
        stage.enable_draw_pika_vt = 1'b1;
        stage.plot                = 1'b1;
      end
      VT_FRAME_WAIT: stage.enable_animate = 1'b1;
      VT_DRAW_HURT: begin
        stage.enable_draw_hurt_meowth = 1'b1;
        stage.plot                    = 1'b1;
        stage.choose                  = 1'b1;
        stage.enable_animate          = 1'b1;
      end
      VT_HOLD: begin
        stage.enable_animate = 1'b1;
        stage.choose         = 1'b1;
      end
      VT_DONE:       attack_done = 1'b1;
      default:       ;
    endcase
  end

  // The only combinational input-to-output path: the frame-advance strobe.
  assign stage.enable_p_vt = (state_q == VT_FRAME_WAIT) & stage.done_animate_vt
                             & ~stage.done_shift;

  vt_attack_control_hp_register u_meowth_hp (
    .clock     (clock),
    .reset_all (reset_all),
    .load      (new_battle),
    .sub_en    (state_q == VT_APPLY),
    .amount    (VT_DAMAGE),
    .hp        (meowth_hp),
    .zero      (meowth_fainted)
  );

  vt_attack_control_hp_register u_pika_hp (
    .clock     (clock),
    .reset_all (reset_all),
    .load      (new_battle),
    .sub_en    (pika_sub),
    .amount    (VT_RECOIL),
    .hp        (pika_hp),
    .zero      (pika_zero)
  );

endmodule

// File: tb/tb_vt_attack_control.sv
// tb_vt_attack_control
// Directed attack scenarios followed by randomized inputs, checked every
// cycle against a behavioural model of the attack sequence, plus literal
// expectations for HP values and pulse counts.
module tb_vt_attack_control;
  import vt_attack_control_pkg::*;

`ifdef VT_RECOIL_EN
  localparam bit RECOIL = 1'b1;
`else
  localparam bit RECOIL = 1'b0;
`endif

  // Phases of an attack as the model sees them.
  localparam int PH_WAIT = 0, PH_WIPE = 1, PH_PIKA = 2, PH_ANIM = 3,
                 PH_HURT = 4, PH_LINGER = 5, PH_HIT = 6, PH_REPORT = 7;

  logic clock = 1'b0;
  logic reset_all, new_battle, start;
  logic busy, attack_done, meowth_fainted;
  logic [HP_W-1:0] meowth_hp, pika_hp;

  vt_attack_control_if stg();

  vt_attack_control dut (
    .clock          (clock),
    .reset_all      (reset_all),
    .new_battle     (new_battle),
    .start          (start),
    .stage          (stg),
    .busy           (busy),
    .attack_done    (attack_done),
    .meowth_hp      (meowth_hp),
    .pika_hp        (pika_hp),
    .meowth_fainted (meowth_fainted)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;
  int p_vt_cnt = 0;
  int done_cnt = 0;

  int m_ph = PH_WAIT;
  int m_mh = 100;
  int m_pk = 100;

  // Behavioural model: advance one cycle using the inputs held this cycle.
  always @(posedge clock) begin
    int nxt;
    nxt = m_ph;
    if (reset_all) begin
      m_ph = PH_WAIT; m_mh = 100; m_pk = 100;
    end else begin
      case (m_ph)
        PH_WAIT:   if (start && m_mh > 0 && (!RECOIL || m_pk > 0)) nxt = PH_WIPE;
        PH_WIPE:   nxt = PH_PIKA;
        PH_PIKA:   if (stg.done_pikachu_vt) nxt = PH_ANIM;
        PH_ANIM:   if (stg.done_shift) nxt = PH_HURT;
                   else if (stg.done_animate_vt) nxt = PH_PIKA;
        PH_HURT:   if (stg.done_hurt_meowth) nxt = PH_LINGER;
        PH_LINGER: if (stg.done_vt) nxt = PH_HIT;
        PH_HIT:    nxt = PH_REPORT;
        default:   nxt = PH_WAIT;
      endcase
      if (new_battle) begin
        m_mh = 100; m_pk = 100;
      end else if (m_ph == PH_HIT) begin
        m_mh = (m_mh > 40) ? m_mh - 40 : 0;
        if (RECOIL) m_pk = (m_pk > 10) ? m_pk - 10 : 0;
      end
      m_ph = nxt;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    logic [9:0] got, exp;
    if (chk_en) begin
      got = {stg.stage_resetn, stg.enable_animate, stg.enable_p_vt,
             stg.enable_draw_pika_vt, stg.enable_draw_hurt_meowth, stg.choose,
             stg.plot, busy, attack_done, meowth_fainted};
      exp = {m_ph != PH_WIPE,
             m_ph == PH_ANIM || m_ph == PH_HURT || m_ph == PH_LINGER,
             m_ph == PH_ANIM && stg.done_animate_vt && !stg.done_shift,
             m_ph == PH_PIKA,
             m_ph == PH_HURT,
             m_ph == PH_HURT || m_ph == PH_LINGER,
             m_ph == PH_PIKA || m_ph == PH_HURT,
             m_ph != PH_WAIT,
             m_ph == PH_REPORT,
             m_mh == 0};
      n_checks++;
      if (got !== exp || int'(meowth_hp) != m_mh || int'(pika_hp) != m_pk) begin
        n_errors++;
        $display("FAIL cycle_cmp t=%0t got=%b mhp=%0d php=%0d required=%b mhp=%0d php=%0d",
                 $time, got, meowth_hp, pika_hp, exp, m_mh, m_pk);
      end
      if (stg.enable_p_vt === 1'b1) p_vt_cnt++;
      if (attack_done === 1'b1) done_cnt++;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(0, 2)) step();
  endtask

  // Stub stage: fixed response script, with random dwell in each phase.
  task automatic run_attack(input int frames, input bit conflict,
                            input bit abort_hold, input bit nb_at_hit);
    p_vt_cnt = 0; done_cnt = 0;
    start = 1'b1; step(); start = 1'b0;
    step();
    idle_gap();
    for (int f = 0; f < frames; f++) begin
      stg.done_pikachu_vt = 1'b1; step(); stg.done_pikachu_vt = 1'b0;
      idle_gap();
      stg.done_animate_vt = 1'b1; step(); stg.done_animate_vt = 1'b0;
      idle_gap();
    end
    stg.done_pikachu_vt = 1'b1; step(); stg.done_pikachu_vt = 1'b0;
    idle_gap();
    stg.done_shift = 1'b1;
    if (conflict) begin
      stg.done_animate_vt = 1'b1;
      #1;
      chk("conflict_p_vt", int'(stg.enable_p_vt), 0);
    end
    step();
    stg.done_animate_vt = 1'b0;
    chk("hurt_entered", int'(stg.enable_draw_hurt_meowth), 1);
    chk("hurt_choose", int'(stg.choose), 1);
    idle_gap();
    stg.done_hurt_meowth = 1'b1; step(); stg.done_hurt_meowth = 1'b0;
    idle_gap();
    if (abort_hold) begin
      reset_all = 1'b1; step(); reset_all = 1'b0;
      stg.done_shift = 1'b0;
      chk("abort_busy", int'(busy), 0);
      return;
    end
    stg.done_vt = 1'b1; step();
    if (nb_at_hit) new_battle = 1'b1;
    step(); new_battle = 1'b0;
    step();
    stg.done_vt = 1'b0; stg.done_shift = 1'b0;
    step();
  endtask

  initial begin
    reset_all = 1'b1; new_battle = 1'b0; start = 1'b0;
    stg.done_animate_vt = 1'b0; stg.done_pikachu_vt = 1'b0; stg.done_shift = 1'b0;
    stg.done_vt = 1'b0; stg.done_hurt_meowth = 1'b0;
    step();
    chk_en = 1'b1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_stage_resetn", int'(stg.stage_resetn), 1);
    step();
    reset_all = 1'b0;
    new_battle = 1'b1; step(); new_battle = 1'b0;
    step();
    chk("nb_meowth_hp", int'(meowth_hp), 100);
    chk("nb_pika_hp", int'(pika_hp), 100);
    chk("nb_busy", int'(busy), 0);

    run_attack(3, 1'b0, 1'b0, 1'b0);
    chk("a1_p_vt_pulses", p_vt_cnt, 3);
    chk("a1_attack_done", done_cnt, 1);
    chk("a1_meowth_hp", int'(meowth_hp), 60);
    chk("a1_pika_hp", int'(pika_hp), RECOIL ? 90 : 100);

    run_attack(1, 1'b0, 1'b0, 1'b0);
    chk("a2_meowth_hp", int'(meowth_hp), 20);
    run_attack(0, 1'b0, 1'b0, 1'b0);
    chk("a3_meowth_hp", int'(meowth_hp), 0);
    chk("a3_fainted", int'(meowth_fainted), 1);
    chk("a3_pika_hp", int'(pika_hp), RECOIL ? 70 : 100);

    start = 1'b1; step(); start = 1'b0;
    chk("a4_busy", int'(busy), 0);
    step();
    chk("a4_busy_late", int'(busy), 0);

    new_battle = 1'b1; step(); new_battle = 1'b0;
    run_attack(2, 1'b1, 1'b0, 1'b0);
    chk("conflict_p_vt_pulses", p_vt_cnt, 2);
    chk("conflict_meowth_hp", int'(meowth_hp), 60);

    run_attack(1, 1'b0, 1'b1, 1'b0);
    chk("abort_attack_done", done_cnt, 0);
    chk("abort_meowth_hp", int'(meowth_hp), 100);

    run_attack(0, 1'b0, 1'b0, 1'b1);
    chk("nbhit_meowth_hp", int'(meowth_hp), 100);
    chk("nbhit_pika_hp", int'(pika_hp), 100);
    chk("nbhit_attack_done", done_cnt, 1);

    for (int i = 0; i < 4000; i++) begin
      reset_all            = ($urandom_range(0, 299) == 0);
      new_battle           = ($urandom_range(0, 39) == 0);
      start                = ($urandom_range(0, 3) == 0);
      stg.done_pikachu_vt  = ($urandom_range(0, 2) == 0);
      stg.done_animate_vt  = ($urandom_range(0, 2) == 0);
      stg.done_shift       = ($urandom_range(0, 3) == 0);
      stg.done_hurt_meowth = ($urandom_range(0, 2) == 0);
      stg.done_vt          = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vt_attack_control.md
# vt_attack_control

Sequencing controller for the Volt Tackle attack. It sits directly upstream of the `volt_tackle` drawing stage and drives that stage's enable, select and reset inputs. It consumes the stage's done flags and gates the VGA plot strobe. When the animation ends it applies damage to the opponent's HP register and reports completion to the battle FSM.

## Interface
- `HP_W`, 8: HP register width.
- `MAX_HP`, 100: HP loaded on `new_battle`.
- `VT_DAMAGE`, 40: opponent HP removed per attack.
- `clock`  in  1  system clock, all state on rising edge.
- `reset_all`  in  1  synchronous, active-high reset.
- `new_battle`  in  1  pulse; reloads both HP registers.
- `start`  in  1  pulse; request one Volt Tackle.
- `done_animate_vt`  in  1  frame pulse from the stage.
- `done_pikachu_vt`  in  1  Pikachu sprite draw complete.
- `done_shift`  in  1  shift phase complete (level).
- `done_vt`  in  1  whole animation complete (level).
- `done_hurt_meowth`  in  1  hurt sprite draw complete.
- `stage_resetn`  out  1  active-low reset to the stage counters.
- `enable_animate`, `enable_p_vt`, `enable_draw_pika_vt`, `enable_draw_hurt_meowth`  out  1 each  stage enables.
- `choose`  out  1  pixel source select: 0 = Pikachu, 1 = Meowth.
- `plot`  out  1  VGA write enable.
- `busy`  out  1  high in any state other than IDLE.
- `attack_done`  out  1  one-cycle completion pulse.
- `meowth_hp`, `pika_hp`  out  HP_W  current HP.
- `meowth_fainted`  out  1  high when `meowth_hp` == 0.

## Operation
States, with their outputs:
- IDLE: no stage enables active.
  - Go to CLEAR on `start` if `meowth_hp` != 0.
  - Otherwise `start` is ignored.
- CLEAR: `stage_resetn` = 0 for exactly one cycle, then go to DRAW_PIKA.
- DRAW_PIKA: `enable_draw_pika_vt` = 1, `plot` = 1, `choose` = 0.
  - Go to FRAME_WAIT on `done_pikachu_vt`.
- FRAME_WAIT: `enable_animate` = 1.
  - If `done_shift`: go to DRAW_HURT. This has priority over the frame pulse.
  - Else if `done_animate_vt`: assert `enable_p_vt` for that single cycle and go to DRAW_PIKA.
- DRAW_HURT: `enable_draw_hurt_meowth` = 1, `plot` = 1, `choose` = 1, `enable_animate` = 1.
  - Go to HOLD on `done_hurt_meowth`.
- HOLD: `enable_animate` = 1, `choose` = 1. Go to DAMAGE on `done_vt`.
- DAMAGE: one cycle.
  - `meowth_hp` <= `meowth_hp` − `VT_DAMAGE`, saturating at 0.
  - Then go to DONE.
- DONE: `attack_done` = 1 for one cycle, then go to IDLE.

Rules common to all states:
- `stage_resetn` = 1 in every state except CLEAR.
- `new_battle` loads both HP registers with `MAX_HP` in any state. It does not change the FSM state.
- If `new_battle` and DAMAGE coincide, `new_battle` wins.
- Arithmetic is unsigned at `HP_W` bits. Compare before subtracting, so the result never wraps.

## Timing
- Reset: state = IDLE, `meowth_hp` = `pika_hp` = `MAX_HP`, `stage_resetn` = 1. All other outputs are 0.
- Reset asserted mid-attack aborts within one cycle. No damage is applied and `attack_done` does not pulse.
- Every output is a registered-state decode with no combinational input-to-output paths, except `enable_p_vt`. `enable_p_vt` = (state == FRAME_WAIT) & `done_animate_vt` & ~`done_shift`.
- `start` in IDLE leads to CLEAR on the next cycle and DRAW_PIKA on the cycle after.
- `busy` rises the cycle after `start` and falls the cycle after `attack_done`.
- `start` while `busy` is high is dropped and is not queued.
- `meowth_hp` updates on the edge that leaves DAMAGE. `attack_done` is high in the following cycle and already sees the new HP.

## Configuration
- `VT_RECOIL_EN` defined:
  - DAMAGE also does `pika_hp` <= `pika_hp` − (`VT_DAMAGE` >> 2), saturating at 0.
  - IDLE additionally refuses `start` when `pika_hp` == 0.
- `VT_RECOIL_EN` undefined: `pika_hp` changes only on reset or `new_battle`.

## Structure
- Shared package holds:
  - the state enum (`VT_IDLE` … `VT_DONE`, 3 bits);
  - `HP_W`, `MAX_HP` and the per-move damage constants, shared with the other attack controllers.
- Natural sub-module: `hp_register`. It is instantiated once per combatant and provides load on `new_battle`, saturating subtract, and a zero flag.

## Test plan
- Reset, then `new_battle` → `meowth_hp` = 100, `pika_hp` = 100, state IDLE, `stage_resetn` = 1.
- `start` with a stub stage giving 3 frames before `done_shift`:
  - exactly 3 single-cycle `enable_p_vt` pulses;
  - then DRAW_HURT with `choose` = 1;
  - `attack_done` once; `meowth_hp` = 60.
- Three full attacks → `meowth_hp` goes 60 → 20 → 0 (saturated, not 236). `meowth_fainted` = 1, and a fourth `start` leaves `busy` = 0.
- `done_shift` and `done_animate_vt` in the same FRAME_WAIT cycle → `enable_p_vt` stays 0 and the next state is DRAW_HURT.
- `reset_all` pulsed during HOLD → IDLE next cycle, no `attack_done`, `meowth_hp` reset to 100.
- With `VT_RECOIL_EN`: one attack → `pika_hp` = 90. `new_battle` in the same cycle as DAMAGE → both HP = 100.
